// File: rtl/conv_mac_unit_if.sv
// Tap-stream input and window-result output lanes of conv_mac_unit.
// The bias lane exists only when CONV_MAC_BIAS_EN is defined.
interface conv_mac_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] weight;
`ifdef CONV_MAC_BIAS_EN
    logic [DATA_W-1:0] bias;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;

`ifdef CONV_MAC_BIAS_EN
    modport master (
        output in_valid, pixel, weight, bias, out_ready,
        input  in_ready, out_valid, acc_out
    );
    modport slave (
        input  in_valid, pixel, weight, bias, out_ready,
        output in_ready, out_valid, acc_out
    );
`else
    modport master (
        output in_valid, pixel, weight, out_ready,
        input  in_ready, out_valid, acc_out
    );
    modport slave (
        input  in_valid, pixel, weight, out_ready,
        output in_ready, out_valid, acc_out
    );
`endif
endinterface

// File: rtl/conv_mac_unit.sv
// Two-stage Q5.11 multiply-accumulate over one kernel window with a clamped Q10.22 result.
// Define CONV_MAC_BIAS_EN to seed each window's accumulator with the sampled bias.
module conv_mac_unit #(
    parameter int unsigned KERNEL_SIZE = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    conv_mac_unit_if.slave bus
);
    localparam int unsigned CNT_W      = $clog2(KERNEL_SIZE);
    localparam int unsigned PROD_W     = 2 * DATA_W;
    localparam int unsigned SUM_W      = ACC_W + CNT_W;
    localparam int unsigned FRAC_SHIFT = 11;

    typedef enum logic [1:0] {
        StAccum,
        StFlush,
        StOutput
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
    logic                     flush_cnt_q, flush_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     load_out;
    logic                     in_ready;
    logic                     accept;
    logic                     first_tap;
    logic                     last_tap;

    logic signed [PROD_W-1:0] pix_ext, wgt_ext, prod_d, prod_q;
    logic                     prod_vld_q, prod_first_q;
    logic signed [SUM_W-1:0]  prod_ext, init_val, acc_q;
    logic [SUM_W-ACC_W:0]     acc_top;
    logic [ACC_W-1:0]         clamp_val, acc_out_q;

    assign in_ready  = (state_q == StAccum) && !rst;
    assign accept    = bus.in_valid && in_ready;
    assign first_tap = (tap_cnt_q == '0);
    assign last_tap  = (tap_cnt_q == CNT_W'(KERNEL_SIZE - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAccum;
            tap_cnt_q   <= '0;
            flush_cnt_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q;
        load_out    = 1'b0;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    if (last_tap) begin
                        tap_cnt_d   = '0;
                        flush_cnt_d = 1'b0;
                        state_d     = StFlush;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CNT_W'(1);
                    end
                end
            end
            StFlush: begin
                // Two cycles: the last product lands in the accumulator, then the sum is clamped.
                if (flush_cnt_q) begin
                    state_d     = StOutput;
                    load_out    = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            StOutput: begin
                if (bus.out_ready) begin
                    state_d     = StAccum;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StAccum;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Stage 1: full-precision product
    assign pix_ext = {{DATA_W{bus.pixel[DATA_W-1]}}, bus.pixel};
    assign wgt_ext = {{DATA_W{bus.weight[DATA_W-1]}}, bus.weight};
    assign prod_d  = pix_ext * wgt_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
        end else begin
            if (accept) begin
                prod_q <= prod_d;
            end
            prod_vld_q   <= accept;
            prod_first_q <= accept && first_tap;
        end
    end

`ifdef CONV_MAC_BIAS_EN
    logic [DATA_W-1:0] bias_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (accept && first_tap) begin
            bias_q <= bus.bias;
        end
    end

    // Q5.11 bias realigned to the Q10.22 accumulator
    assign init_val = {{(SUM_W - DATA_W - FRAC_SHIFT){bias_q[DATA_W-1]}}, bias_q,
                       {FRAC_SHIFT{1'b0}}};
`else
    assign init_val = '0;
`endif

    // Stage 2: accumulator, reseeded on the first tap of each window
    assign prod_ext = {{(SUM_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (prod_vld_q) begin
            acc_q <= (prod_first_q ? init_val : acc_q) + prod_ext;
        end
    end

    // Saturate whenever the bits above the output sign bit are not a pure sign extension
    assign acc_top = acc_q[SUM_W-1:ACC_W-1];

    always_comb begin
        clamp_val = acc_q[ACC_W-1:0];
        if (!(&acc_top) && (|acc_top)) begin
            clamp_val = acc_q[SUM_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                       : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out_q <= '0;
        end else if (load_out) begin
            acc_out_q <= clamp_val;
        end
    end
endmodule

// File: tb/tb_conv_mac_unit.sv
// Randomized self-checking bench for conv_mac_unit against an integer window-sum model.
// Build with CONV_MAC_BIAS_EN defined to also exercise the bias lane.
module tb_conv_mac_unit;
    localparam int K = 25;

    logic clk;
    logic rst;

    conv_mac_unit_if #(.DATA_W(16), .ACC_W(32)) bus ();

    conv_mac_unit #(
        .KERNEL_SIZE(K),
        .DATA_W     (16),
        .ACC_W      (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] pix_a [K];
    logic signed [15:0] wt_a  [K];
    logic signed [15:0] win_bias;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact window sum in 64-bit integers, then clamp to 32-bit signed.
    function automatic logic [31:0] model_sum();
        longint s = 0;
`ifdef CONV_MAC_BIAS_EN
        s = longint'(win_bias) * 2048;
`endif
        for (int i = 0; i < K; i++) s += longint'(pix_a[i]) * longint'(wt_a[i]);
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic fill(input logic [15:0] p, input logic [15:0] w);
        for (int i = 0; i < K; i++) begin
            pix_a[i] = p;
            wt_a[i]  = w;
        end
    endtask

    // Called just after an edge; returns just after the edge accepting the final tap.
    task automatic send_window(input int n, input bit gaps);
        bit ok;
        bit rdy;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.pixel    = 16'($urandom);
                    bus.weight   = 16'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.pixel    = pix_a[i];
            bus.weight   = wt_a[i];
`ifdef CONV_MAC_BIAS_EN
            bus.bias = (i == 0) ? win_bias : 16'($urandom);
`endif
            ok = 1'b0;
            for (int c = 0; c < 64; c++) begin
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            check_eq("tap_accepted", 64'(ok), 64'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after the last tap edge; hold>0 keeps out_ready low that many cycles.
    task automatic collect(input string tag, input logic [31:0] exp, input int hold);
        int          n;
        logic [31:0] held;
        bus.out_ready = (hold == 0);
        check_eq({tag, "_inready_flush"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'd2);
        check_eq({tag, "_acc_out"}, 64'(bus.acc_out), 64'(exp));
        held = bus.acc_out;
        for (int c = 0; c < hold; c++) begin
            bus.in_valid = 1'($urandom);
            bus.pixel    = 16'h7FFF;
            bus.weight   = 16'h7FFF;
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check_eq({tag, "_hold_data"}, 64'(bus.acc_out), 64'(held));
            check_eq({tag, "_hold_inready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_inready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.pixel     = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b1;
        win_bias      = '0;
`ifdef CONV_MAC_BIAS_EN
        bus.bias = '0;
`endif
        #1;
        check_eq("rst_inready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_outvalid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_accout", 64'(bus.acc_out), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_eq("post_rst_inready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Unit sum: 25 x (1.0 * 1.0)
        fill(16'h0800, 16'h0800);
        send_window(K, 1'b0);
        collect("unit", 32'h0640_0000, 0);

        fill(16'h7FFF, 16'h7FFF);
        send_window(K, 1'b0);
        collect("pos_sat", model_sum(), 0);
        check_eq("pos_sat_ref", 64'(model_sum()), 64'h7FFF_FFFF);

        fill(16'h8000, 16'h7FFF);
        send_window(K, 1'b0);
        collect("neg_sat", 32'h8000_0000, 0);

        // Backpressure with stray in_valid pulses, then a clean back-to-back window
        fill(16'h0800, 16'h0800);
        send_window(K, 1'b0);
        collect("bp", 32'h0640_0000, 5);
        send_window(K, 1'b0);
        collect("bp_next", 32'h0640_0000, 0);

        // Reset mid-window
        fill(16'h7FFF, 16'h7FFF);
        send_window(10, 1'b0);
        #2 rst = 1'b1;
        #1 check_eq("midrst_inready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        fill(16'h0800, 16'h0800);
        send_window(K, 1'b0);
        collect("after_rst", 32'h0640_0000, 0);

        // Reset while a result is pending drops it
        bus.out_ready = 1'b0;
        send_window(K, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_eq("pend_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("pend_drop_valid", 64'(bus.out_valid), 64'd0);
        check_eq("pend_drop_data", 64'(bus.acc_out), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        send_window(K, 1'b1);
        collect("bubbles", 32'h0640_0000, 0);

`ifdef CONV_MAC_BIAS_EN
        win_bias = 16'sh0800;
        fill(16'h0000, 16'h0000);
        send_window(K, 1'b0);
        collect("bias_pos", 32'h0040_0000, 0);
        win_bias = 16'shF800;
        fill(16'h0800, 16'h0800);
        send_window(K, 1'b1);
        collect("bias_neg", 32'h0600_0000, 0);
`endif

        // Randomized windows against the model
        for (int w = 0; w < 8; w++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < K; i++) begin
                pix_a[i] = 16'($urandom);
                wt_a[i]  = 16'($urandom);
                if (mode == 1) begin
                    pix_a[i] = pix_a[i] >>> 3;
                    wt_a[i]  = wt_a[i] >>> 3;
                end else if (mode == 2) begin
                    pix_a[i] = pix_a[i][0] ? 16'sh7FFF : 16'sh8000;
                end
            end
`ifdef CONV_MAC_BIAS_EN
            win_bias = 16'($urandom);
`endif
            send_window(K, 1'($urandom));
            collect("rand", model_sum(), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
